bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive dbus grants allowed while ibus waits before ibus is forced.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 i_valid  input  1  fetch request valid; held until i_addr_ok.
REQ-005 i_addr  input  32  fetch address.
REQ-006 i_addr_ok  output  1  fetch address accepted.
REQ-007 i_data_ok  output  1  fetch data returned.
REQ-008 i_data  output  32  fetch read data.
REQ-009 d_valid  input  1  data request valid; held until d_addr_ok.
REQ-010 d_addr  input  32  data address.
REQ-011 d_write  input  1  1 = store, 0 = load.
REQ-012 d_strobe  input  4  byte enables for stores.
REQ-013 d_wdata  input  32  store data.
REQ-014 d_addr_ok  output  1  data address accepted.
REQ-015 d_data_ok  output  1  data transaction complete.
REQ-016 d_data  output  32  load read data.
REQ-017 m_valid, m_addr[32], m_write, m_strobe[4], m_wdata[32]  outputs  shared memory request.
REQ-018 m_addr_ok, m_data_ok  input  1 each; m_data  input  32  shared memory response.

Function
REQ-019 FSM states: IDLE, REQ (address phase), WAIT (data phase); at most one transaction outstanding.
REQ-020 IDLE: if d_valid only, owner=D; if i_valid only, owner=I; if both, owner=D unless starve count == STARVE_LIMIT, then owner=I; go to REQ next cycle; m_valid=0 in IDLE.
REQ-021 Grant latency: requester valid in cycle N (state IDLE) -> m_valid=1 in cycle N+1.
REQ-022 REQ: m_valid=1; m_addr/m_write/m_strobe/m_wdata driven from owner's live inputs; ibus owner forces m_write=0, m_strobe=0, m_wdata=0.
REQ-023 REQ: owner's addr_ok = m_addr_ok; on m_addr_ok go to WAIT, or to IDLE if m_data_ok also high that cycle.
REQ-024 REQ: owner's valid dropping before addr_ok abandons the request; return to IDLE, m_valid=0 next cycle.
REQ-025 WAIT: m_valid=0; owner's data_ok = m_data_ok; on m_data_ok return to IDLE.
REQ-026 i_data and d_data = m_data combinationally; meaningful only with corresponding data_ok.
REQ-027 Non-owner addr_ok and data_ok are 0 in every state; never both addr_ok (or both data_ok) high in one cycle.
REQ-028 Starve counter (3 bits, saturating at STARVE_LIMIT): +1 on each D grant with i_valid=1; cleared on every I grant; unchanged on D grant with i_valid=0.
REQ-029 Back-to-back: after completion in cycle N (return to IDLE), next grant decided in cycle N+1, m_valid in N+2.
REQ-030 m_addr_ok/m_data_ok arriving in IDLE are ignored; no requester sees them.

Reset
REQ-031 reset=1 at posedge: state=IDLE, owner=D, starve count=0.
REQ-032 During and immediately after reset all outputs are 0: m_valid, m_write, m_strobe, m_addr, m_wdata, all addr_ok/data_ok.
REQ-033 Reset in REQ or WAIT abandons the transaction; no data_ok is forwarded for it.

Verification
REQ-034 i_valid only, addr 0xBFC00000; m_addr_ok at N+2, m_data_ok=1 with data 0x24020001 at N+4 -> m_valid N+1..N+2, i_addr_ok at N+2, i_data_ok/i_data=0x24020001 at N+4, d_* oks stay 0.
REQ-035 i_valid and d_valid together, d store addr 0x80000010 strobe 0xF wdata 0xDEADBEEF -> D granted first, m_write=1, m_wdata=0xDEADBEEF; I granted after D completes.
REQ-036 Both valid continuously, all memory responses single-cycle -> exactly 4 D grants then 1 I grant, repeating; counter 0 after each I grant.
REQ-037 m_addr_ok and m_data_ok high same cycle as first m_valid -> addr_ok and data_ok pulse together to owner; state IDLE next cycle.
REQ-038 reset asserted during WAIT, then m_data_ok pulses after reset release -> no data_ok to either requester; all outputs 0 during reset.
REQ-039 d_valid dropped in REQ before m_addr_ok -> m_valid 0 next cycle; d_addr_ok never asserted.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter: an instruction-fetch port (i_*) and a data port
// (d_*) share one memory request/response channel (m_*). Only one
// transaction is outstanding at a time. The data port wins ties unless the
// fetch port has been passed over STARVE_LIMIT times in a row.
module bus_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        i_valid,
  input  logic [31:0] i_addr,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  output logic [31:0] i_data,

  input  logic        d_valid,
  input  logic [31:0] d_addr,
  input  logic        d_write,
  input  logic [3:0]  d_strobe,
  input  logic [31:0] d_wdata,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic [31:0] d_data,

  output logic        m_valid,
  output logic [31:0] m_addr,
  output logic        m_write,
  output logic [3:0]  m_strobe,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_data
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  // The starve counter is three bits wide, so the limit is truncated to fit.
  localparam logic [2:0] LIMIT = STARVE_LIMIT[2:0];

  logic [1:0] r_state;
  logic       r_ownerI;
  logic [2:0] r_starve;

  logic       w_inReq;
  logic       w_inWait;
  logic       w_ownerValid;
  logic       w_grantI;
  logic       w_addrOk;
  logic       w_dataOk;

  assign w_inReq      = (r_state == ST_REQ);
  assign w_inWait     = (r_state == ST_WAIT);
  assign w_ownerValid = r_ownerI ? i_valid : d_valid;

  // The fetch port wins when it is the only requester, or when both request
  // and the data port has already used up its run of consecutive grants.
  assign w_grantI = i_valid && (!d_valid || (r_starve == LIMIT));

  // Handshakes from memory only mean something while a transaction is live.
  // A same-cycle data_ok in the address phase completes the transaction
  // together with addr_ok.
  assign w_addrOk = w_inReq && m_addr_ok;
  assign w_dataOk = m_data_ok && (w_inWait || w_addrOk);

  assign i_addr_ok = w_addrOk &&  r_ownerI;
  assign d_addr_ok = w_addrOk && !r_ownerI;
  assign i_data_ok = w_dataOk &&  r_ownerI;
  assign d_data_ok = w_dataOk && !r_ownerI;

  assign i_data = m_data;
  assign d_data = m_data;

  // The request channel carries the owner's live inputs in the address phase
  // and is zero otherwise; a fetch never writes.
  always_comb begin
    m_valid  = 1'b0;
    m_addr   = 32'h0;
    m_write  = 1'b0;
    m_strobe = 4'h0;
    m_wdata  = 32'h0;
    if (w_inReq) begin
      m_valid = 1'b1;
      if (r_ownerI) begin
        m_addr = i_addr;
      end else begin
        m_addr   = d_addr;
        m_write  = d_write;
        m_strobe = d_strobe;
        m_wdata  = d_wdata;
      end
    end
  end

  // Transaction sequencing, ownership and starvation bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_ownerI <= 1'b0;
      r_starve <= 3'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_valid || d_valid) begin
            r_state  <= ST_REQ;
            r_ownerI <= w_grantI;
            if (w_grantI) begin
              r_starve <= 3'd0;
            end else if (i_valid && (r_starve != LIMIT)) begin
              r_starve <= r_starve + 3'd1;
            end
          end
        end
        ST_REQ: begin
          if (m_addr_ok) begin
            r_state <= m_data_ok ? ST_IDLE : ST_WAIT;
          end else if (!w_ownerValid) begin
            r_state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (m_data_ok) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios followed by a randomized run
// against a transaction-level model of the arbitration rules.
module tb_bus_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid;
  logic [31:0] i_addr;
  logic        i_addr_ok;
  logic        i_data_ok;
  logic [31:0] i_data;
  logic        d_valid;
  logic [31:0] d_addr;
  logic        d_write;
  logic [3:0]  d_strobe;
  logic [31:0] d_wdata;
  logic        d_addr_ok;
  logic        d_data_ok;
  logic [31:0] d_data;
  logic        m_valid;
  logic [31:0] m_addr;
  logic        m_write;
  logic [3:0]  m_strobe;
  logic [31:0] m_wdata;
  logic        m_addr_ok;
  logic        m_data_ok;
  logic [31:0] m_data;

  int nChecks = 0;
  int nErrors = 0;

  bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_addr(i_addr), .i_addr_ok(i_addr_ok),
    .i_data_ok(i_data_ok), .i_data(i_data),
    .d_valid(d_valid), .d_addr(d_addr), .d_write(d_write),
    .d_strobe(d_strobe), .d_wdata(d_wdata), .d_addr_ok(d_addr_ok),
    .d_data_ok(d_data_ok), .d_data(d_data),
    .m_valid(m_valid), .m_addr(m_addr), .m_write(m_write),
    .m_strobe(m_strobe), .m_wdata(m_wdata), .m_addr_ok(m_addr_ok),
    .m_data_ok(m_data_ok), .m_data(m_data)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start of a cycle: 1 time unit after the rising edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic iv, input logic dv, input logic aok, input logic dok);
    i_valid   = iv;
    d_valid   = dv;
    m_addr_ok = aok;
    m_data_ok = dok;
  endtask

  task automatic checkAllOutputsZero(input string tag);
    checkOutput({tag, "_mValid"}, m_valid, 0);
    checkOutput({tag, "_mAddr"}, m_addr, 0);
    checkOutput({tag, "_mWrite"}, m_write, 0);
    checkOutput({tag, "_mStrobe"}, m_strobe, 0);
    checkOutput({tag, "_mWdata"}, m_wdata, 0);
    checkOutput({tag, "_oks"}, {i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}, 0);
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 0);
    m_data = 0;
    reset  = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic logic [31:0] dataOf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5A5_3C3C;
  endfunction

  // Randomized-run model state.
  logic        ownerI, expI, prevI, prevD, prevIdle, prevMValid;
  logic        memWait, waitNow, dropI, dropD, expAddrOk, expDataOk, dPendWrite;
  logic [31:0] memAddr, iPendAddr, dPendAddr;
  int          starveM;
  int          grants;

  initial begin
    reset = 1'b1;
    i_addr = 0; d_addr = 0; d_write = 0; d_strobe = 0; d_wdata = 0; m_data = 0;
    applyStimulus(1, 1, 1, 1);
    d_addr = 32'h8000_0040; d_write = 1; d_strobe = 4'hF; d_wdata = 32'h1111_2222;
    i_addr = 32'hBFC0_0040;

    // Outputs stay quiet under reset even with everything asserted.
    nextCycle();
    #2;
    checkAllOutputsZero("inReset");

    // Release reset with a load pending: still idle in the first cycle.
    nextCycle();
    reset = 1'b0;
    applyStimulus(0, 1, 0, 0);
    d_write = 0;
    #2;
    checkAllOutputsZero("afterReset");

    // Grant one cycle later, then abandon before addr_ok.
    nextCycle();
    #2;
    checkOutput("abandon_mValid", m_valid, 1);
    checkOutput("abandon_mAddr", m_addr, 32'h8000_0040);
    checkOutput("abandon_dAddrOk", d_addr_ok, 0);
    nextCycle();
    d_valid = 0;
    #2;
    checkOutput("abandon_dAddrOkDrop", d_addr_ok, 0);
    nextCycle();
    #2;
    checkOutput("abandon_mValidGone", m_valid, 0);
    checkOutput("abandon_dAddrOkAfter", d_addr_ok, 0);

    // Memory handshakes in idle are ignored.
    nextCycle();
    applyStimulus(0, 0, 1, 1);
    #2;
    checkOutput("idleSpurious_oks", {i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0);
    #2;
    checkOutput("idleSpurious_mValid", m_valid, 0);

    // Single fetch with addr_ok at N+2 and data at N+4.
    nextCycle();
    i_addr = 32'hBFC0_0000;
    applyStimulus(1, 0, 0, 0);
    #2;
    checkOutput("fetch_N_mValid", m_valid, 0);
    nextCycle();
    #2;
    checkOutput("fetch_N1_mValid", m_valid, 1);
    checkOutput("fetch_N1_mAddr", m_addr, 32'hBFC0_0000);
    checkOutput("fetch_N1_iAddrOk", i_addr_ok, 0);
    nextCycle();
    m_addr_ok = 1;
    #2;
    checkOutput("fetch_N2_mValid", m_valid, 1);
    checkOutput("fetch_N2_iAddrOk", i_addr_ok, 1);
    checkOutput("fetch_N2_dAddrOk", d_addr_ok, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0);
    #2;
    checkOutput("fetch_N3_mValid", m_valid, 0);
    checkOutput("fetch_N3_iDataOk", i_data_ok, 0);
    nextCycle();
    m_data_ok = 1;
    m_data = 32'h2402_0001;
    #2;
    checkOutput("fetch_N4_iDataOk", i_data_ok, 1);
    checkOutput("fetch_N4_iData", i_data, 32'h2402_0001);
    checkOutput("fetch_N4_dDataOk", d_data_ok, 0);
    nextCycle();
    m_data_ok = 0;
    m_data = 0;
    #2;
    checkOutput("fetch_N5_iDataOk", i_data_ok, 0);
    checkOutput("fetch_N5_mValid", m_valid, 0);

    // Both request: store goes first, completing in one cycle, then fetch.
    nextCycle();
    i_addr = 32'hBFC0_0000;
    d_addr = 32'h8000_0010; d_write = 1; d_strobe = 4'hF; d_wdata = 32'hDEAD_BEEF;
    applyStimulus(1, 1, 0, 0);
    #2;
    checkOutput("both_C0_mValid", m_valid, 0);
    nextCycle();
    m_addr_ok = 1; m_data_ok = 1;
    #2;
    checkOutput("both_C1_mAddr", m_addr, 32'h8000_0010);
    checkOutput("both_C1_mWrite", m_write, 1);
    checkOutput("both_C1_mStrobe", m_strobe, 4'hF);
    checkOutput("both_C1_mWdata", m_wdata, 32'hDEAD_BEEF);
    checkOutput("both_C1_dOks", {d_addr_ok, d_data_ok}, 2'b11);
    checkOutput("both_C1_iOks", {i_addr_ok, i_data_ok}, 2'b00);
    nextCycle();
    applyStimulus(1, 0, 0, 0);
    #2;
    checkOutput("both_C2_mValid", m_valid, 0);
    nextCycle();
    m_addr_ok = 1; m_data_ok = 1; m_data = 32'h0BAD_F00D;
    #2;
    checkOutput("both_C3_mAddr", m_addr, 32'hBFC0_0000);
    checkOutput("both_C3_mWriteFields", {m_write, m_strobe, m_wdata}, 0);
    checkOutput("both_C3_iOks", {i_addr_ok, i_data_ok}, 2'b11);
    checkOutput("both_C3_dOks", {d_addr_ok, d_data_ok}, 2'b00);
    checkOutput("both_C3_iData", i_data, 32'h0BAD_F00D);
    nextCycle();
    applyStimulus(0, 0, 0, 0);
    m_data = 0;
    #2;
    checkOutput("both_C4_mValid", m_valid, 0);
    checkOutput("both_C4_iOks", {i_addr_ok, i_data_ok}, 2'b00);

    // Continuous contention with single-cycle memory: D,D,D,D,I repeating.
    i_addr = 32'hBFC0_0100;
    d_addr = 32'h8000_0100; d_write = 0; d_strobe = 0; d_wdata = 0;
    applyStimulus(1, 1, 0, 0);
    grants = 0;
    for (int c = 0; c < 60 && grants < 10; c++) begin
      nextCycle();
      m_addr_ok = m_valid;
      m_data_ok = m_valid;
      #2;
      if (m_valid) begin
        checkOutput($sformatf("starvePattern_g%0d", grants), m_addr == i_addr, (grants % 5) == 4);
        grants++;
      end
    end
    checkOutput("starveGrantCount", grants, 10);
    doReset();

    // Reset during the data phase drops the transaction.
    nextCycle();
    d_addr = 32'h8000_0020; d_write = 0;
    applyStimulus(0, 1, 0, 0);
    #2;
    nextCycle();
    m_addr_ok = 1;
    #2;
    checkOutput("rstWait_dAddrOk", d_addr_ok, 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0);
    reset = 1'b1;
    #2;
    checkOutput("rstWait_inWait_mValid", m_valid, 0);
    nextCycle();
    #2;
    checkAllOutputsZero("rstWait_during");
    nextCycle();
    reset = 1'b0;
    m_data_ok = 1; m_data = 32'h1234_5678;
    #2;
    checkOutput("rstWait_lateDataOk", {i_data_ok, d_data_ok}, 2'b00);
    nextCycle();
    m_data_ok = 0; m_data = 0;
    #2;
    checkOutput("rstWait_quiet_mValid", m_valid, 0);
    doReset();

    // Randomized traffic against the transaction-level model.
    memWait = 0; dropI = 0; dropD = 0; ownerI = 0; starveM = 0;
    prevI = 0; prevD = 0; prevIdle = 0; prevMValid = 0;
    memAddr = 0; iPendAddr = 0; dPendAddr = 0; dPendWrite = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      nextCycle();
      if (dropI) begin i_valid = 0; dropI = 0; end
      if (dropD) begin d_valid = 0; dropD = 0; end
      if (!i_valid && $urandom_range(1, 0) == 1) begin
        i_valid = 1;
        i_addr  = 32'hBFC0_0000 | ($urandom & 32'h0000_FFFC);
      end
      if (!d_valid && $urandom_range(1, 0) == 1) begin
        d_valid  = 1;
        d_addr   = 32'h8000_0000 | ($urandom & 32'h0000_FFFC);
        d_write  = 1'($urandom);
        d_strobe = 4'($urandom);
        d_wdata  = $urandom;
      end
      waitNow = memWait;
      #1;
      m_addr_ok = 0; m_data_ok = 0; m_data = $urandom;
      if (m_valid) begin
        if ($urandom_range(1, 0) == 1) begin
          m_addr_ok = 1;
          memAddr = m_addr;
          if ($urandom_range(2, 0) == 0) begin
            m_data_ok = 1;
            m_data = dataOf(memAddr);
          end else begin
            memWait = 1;
          end
        end
      end else if (memWait) begin
        if ($urandom_range(1, 0) == 1) begin
          m_data_ok = 1;
          m_data = dataOf(memAddr);
          memWait = 0;
        end
      end else begin
        m_addr_ok = ($urandom_range(3, 0) == 0);
        m_data_ok = ($urandom_range(3, 0) == 0);
      end
      #1;
      if (prevIdle) checkOutput("rnd_grantLatency", m_valid, prevI | prevD);
      if (m_valid && !prevMValid) begin
        expI = prevI && (!prevD || starveM == LIMIT);
        checkOutput("rnd_grantOwner", m_addr[31:28] == 4'hB, expI);
        ownerI = expI;
        if (expI) starveM = 0;
        else if (prevI && starveM < LIMIT) starveM++;
      end
      if (m_valid) begin
        checkOutput("rnd_mAddr", m_addr, ownerI ? i_addr : d_addr);
        checkOutput("rnd_mWrite", m_write, ownerI ? 1'b0 : d_write);
        checkOutput("rnd_mStrobe", m_strobe, ownerI ? 4'h0 : d_strobe);
        checkOutput("rnd_mWdata", m_wdata, ownerI ? 32'h0 : d_wdata);
      end
      expAddrOk = m_valid && m_addr_ok;
      expDataOk = m_data_ok && (waitNow || expAddrOk);
      checkOutput("rnd_iAddrOk", i_addr_ok, expAddrOk && ownerI);
      checkOutput("rnd_dAddrOk", d_addr_ok, expAddrOk && !ownerI);
      checkOutput("rnd_iDataOk", i_data_ok, expDataOk && ownerI);
      checkOutput("rnd_dDataOk", d_data_ok, expDataOk && !ownerI);
      if (expAddrOk) begin
        if (ownerI) begin
          iPendAddr = i_addr;
          dropI = 1;
        end else begin
          dPendAddr = d_addr;
          dPendWrite = d_write;
          dropD = 1;
        end
      end
      if (expDataOk && ownerI) checkOutput("rnd_iData", i_data, dataOf(iPendAddr));
      if (expDataOk && !ownerI && !dPendWrite) checkOutput("rnd_dData", d_data, dataOf(dPendAddr));
      prevIdle   = !m_valid && !waitNow;
      prevI      = i_valid;
      prevD      = d_valid;
      prevMValid = m_valid;
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
